weight_stream_ctrl: RTL and testbench

Sequencer that loads one CNN layer's filter bank from weight memory, stores it as the K x (C·wH·wH) row-major matrix the GEMM engine consumes, and streams that matrix to the GEMM array as P-element tiles under a valid/ready handshake. It sits between the weight SRAM and the GEMM input port. It replaces the purely combinational weight flattening with a buffered, memory-driven path.

---
 rtl/weight_pkg.sv | 17 +
 rtl/weight_tile_buffer.sv | 42 ++++
 rtl/weight_stream_ctrl.sv | 166 ++++++++++++++++
 tb/tb_weight_stream_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared types and helpers for the weight streaming path.
package weight_pkg;

  localparam int BF16_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    STREAM
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/weight_tile_buffer.sv
// K x N weight store: one synchronous write port, combinational P-wide tile read
// at (k, t) with zero padding past the end of a row.
module weight_tile_buffer #(
  parameter int K  = 10,
  parameter int N  = 75,
  parameter int P  = 8,
  parameter int BW = 16,
  parameter int AW = 10,
  parameter int KW = 4,
  parameter int TW = 4
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [BW-1:0]   wdata_i,
  input  logic [KW-1:0]   k_i,
  input  logic [TW-1:0]   t_i,
  output logic [P*BW-1:0] tile_o
);

  logic [BW-1:0] mem_q [K*N];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    int col;
    col    = 0;
    tile_o = '0;
    for (int j = 0; j < P; j++) begin
      col = int'(t_i) * P + j;
      // Columns beyond N belong to the padded tail of the last tile in a row.
      if (col < N) begin
        tile_o[j*BW +: BW] = mem_q[AW'(int'(k_i) * N + col)];
      end
    end
  end

endmodule

// File: rtl/weight_stream_ctrl.sv
// Loads a layer's filter bank from weight SRAM into a K x N buffer and streams
// it to the GEMM port as P-element tiles under valid/ready.
module weight_stream_ctrl
  import weight_pkg::*;
#(
  parameter int K  = 10,
  parameter int C  = 3,
  parameter int WH = 5,
  parameter int BW = BF16_W,
  parameter int P  = 8,
  localparam int N  = C * WH * WH,
  localparam int T  = ceil_div(N, P),
  localparam int AW = (K * N > 1) ? $clog2(K * N) : 1,
  localparam int KW = (K > 1) ? $clog2(K) : 1,
  localparam int TW = (T > 1) ? $clog2(T) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            reuse,
  output logic            busy,
  output logic            done,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [BW-1:0]   mem_rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [P*BW-1:0] out_data,
  output logic [KW-1:0]   out_k,
  output logic [TW-1:0]   out_tile,
  output logic            out_last
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(K * N - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(K - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(T - 1);

  state_t          state_q, state_d;
  logic            loaded_q, loaded_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            out_valid_q, out_valid_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   t_q, t_d;
  logic            done_q, done_d;
  logic            rd_vld_q;
  logic [AW-1:0]   rd_addr_q;
  logic            last_tile;
  logic [P*BW-1:0] tile;

  assign last_tile = (k_q == K_LAST) && (t_q == T_LAST);

  always_comb begin
    state_d     = state_q;
    loaded_d    = loaded_q;
    rd_en_d     = rd_en_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    k_d         = k_q;
    t_d         = t_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!reuse || !loaded_q) begin
            state_d = LOAD;
            rd_en_d = 1'b1;
            addr_d  = '0;
          end else begin
            state_d     = STREAM;
            out_valid_d = 1'b1;
            k_d         = '0;
            t_d         = '0;
          end
        end
      end
      LOAD: begin
        if (addr_q == ADDR_LAST) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // The final read word lands in the buffer on this edge.
        loaded_d    = 1'b1;
        state_d     = STREAM;
        out_valid_d = 1'b1;
        k_d         = '0;
        t_d         = '0;
      end
      STREAM: begin
        if (out_valid_q && out_ready) begin
          if (last_tile) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (t_q == T_LAST) begin
            t_d = '0;
            k_d = k_q + 1'b1;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      loaded_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      k_q         <= '0;
      t_q         <= '0;
      done_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      loaded_q    <= loaded_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      k_q         <= k_d;
      t_q         <= t_d;
      done_q      <= done_d;
      // Read data returns one cycle after the strobe; remember which address it answers.
      rd_vld_q    <= rd_en_q;
      rd_addr_q   <= addr_q;
    end
  end

  weight_tile_buffer #(
    .K (K),
    .N (N),
    .P (P),
    .BW(BW),
    .AW(AW),
    .KW(KW),
    .TW(TW)
  ) u_buf (
    .clk_i  (clk),
    .we_i   (rd_vld_q),
    .waddr_i(rd_addr_q),
    .wdata_i(mem_rd_data),
    .k_i    (k_q),
    .t_i    (t_q),
    .tile_o (tile)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? tile : '0;
  assign out_k     = k_q;
  assign out_tile  = t_q;
  assign out_last  = out_valid_q && last_tile;

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench: small K=2,C=1,wH=2,P=3 instance driven from a job table plus
// hand-written abort sequence, and a default-parameter instance for padding/count.
module tb_weight_stream_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small instance: N=4, T=2, AW=3, KW=1, TW=1
  logic        start = 1'b0, reuse = 1'b0, out_ready = 1'b1;
  logic        busy, done, mem_rd_en, out_valid, out_last;
  logic [2:0]  mem_addr;
  logic [15:0] mem_rd_data;
  logic [47:0] out_data;
  logic [0:0]  out_k, out_tile;

  weight_stream_ctrl #(.K(2), .C(1), .WH(2), .BW(16), .P(3)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse(reuse), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_k(out_k), .out_tile(out_tile), .out_last(out_last)
  );

  always @(posedge clk) mem_rd_data <= mem_rd_en ? (16'h3F80 + 16'(mem_addr)) : 16'hDEAD;

  // Default instance: N=75, T=10, AW=10, KW=4, TW=4
  logic         b_start = 1'b0, b_reuse = 1'b0, b_out_ready = 1'b1;
  logic         b_busy, b_done, b_mem_rd_en, b_out_valid, b_out_last;
  logic [9:0]   b_mem_addr;
  logic [15:0]  b_mem_rd_data;
  logic [127:0] b_out_data;
  logic [3:0]   b_out_k, b_out_tile;

  weight_stream_ctrl dut_b (
    .clk(clk), .rst(rst), .start(b_start), .reuse(b_reuse), .busy(b_busy), .done(b_done),
    .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr), .mem_rd_data(b_mem_rd_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_k(b_out_k), .out_tile(b_out_tile), .out_last(b_out_last)
  );

  always @(posedge clk) b_mem_rd_data <= b_mem_rd_en ? (16'h3F80 + 16'(b_mem_addr)) : 16'hDEAD;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          k;
    int          t;
    logic [47:0] data;
    int          last;
  } tile_t;

  typedef struct {
    int reuse;
    int stall_tile;
    int stall_len;
    int inject_cyc;
    int exp_rd;
    int exp_first_valid;
  } job_t;

  tile_t exp_tiles [4];
  job_t  jobs [4];

  task automatic run_job(input job_t j);
    int nrd, ntx, ndone, used, window, edone;
    bit seen;
    nrd = 0; ntx = 0; ndone = 0; used = 0; seen = 0;
    edone  = j.exp_first_valid + 4 + j.stall_len;
    window = edone + 5;
    @(negedge clk);
    start = 1'b1; reuse = j.reuse[0]; out_ready = 1'b1;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      start = (c == j.inject_cyc);
      if (out_valid && ntx == j.stall_tile && used < j.stall_len) begin
        out_ready = 1'b0;
        used++;
      end else begin
        out_ready = 1'b1;
      end
      if (mem_rd_en) begin
        chk("rd_addr", 128'(mem_addr), 128'(nrd));
        chk("rd_cycle", 128'(c), 128'(nrd + 1));
        nrd++;
      end
      if (out_valid) begin
        if (!seen) begin
          chk("first_valid_cycle", 128'(c), 128'(j.exp_first_valid));
          seen = 1;
        end
        if (ntx < 4) begin
          chk("tile_k", 128'(out_k), 128'(exp_tiles[ntx].k));
          chk("tile_t", 128'(out_tile), 128'(exp_tiles[ntx].t));
          chk("tile_data", 128'(out_data), 128'(exp_tiles[ntx].data));
          chk("tile_last", 128'(out_last), 128'(exp_tiles[ntx].last));
        end else begin
          chk("extra_tile", 128'(1), 128'(0));
        end
        if (out_ready) ntx++;
      end
      if (done) begin
        ndone++;
        chk("done_cycle", 128'(c), 128'(edone));
        chk("busy_at_done", 128'(busy), 128'(0));
      end
    end
    start = 1'b0; out_ready = 1'b1;
    chk("rd_count", 128'(nrd), 128'(j.exp_rd));
    chk("tile_count", 128'(ntx), 128'(4));
    chk("done_count", 128'(ndone), 128'(1));
  endtask

  initial begin
    bit found;
    int ntb, bk, bt, col;
    bit bdone;
    logic [127:0] expv;

    exp_tiles[0] = '{0, 0, {16'h3F82, 16'h3F81, 16'h3F80}, 0};
    exp_tiles[1] = '{0, 1, {16'h0000, 16'h0000, 16'h3F83}, 0};
    exp_tiles[2] = '{1, 0, {16'h3F86, 16'h3F85, 16'h3F84}, 0};
    exp_tiles[3] = '{1, 1, {16'h0000, 16'h0000, 16'h3F87}, 1};

    //            reuse stall_tile stall_len inject rd first_valid
    jobs[0] = '{0, -1, 0, 0, 8, 10};   // full load, ready high
    jobs[1] = '{0,  1, 3, 0, 8, 10};   // stall 3 cycles on (k0,t1)
    jobs[2] = '{1, -1, 0, 0, 0,  1};   // reuse loaded buffer
    jobs[3] = '{1, -1, 0, 2, 0,  1};   // start pulsed mid-STREAM

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_rd_en", 128'(mem_rd_en), 128'(0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_k", 128'(out_k), 128'(0));
    chk("rst_tile", 128'(out_tile), 128'(0));
    chk("rst_last", 128'(out_last), 128'(0));
    chk("rst_b_busy", 128'(b_busy), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_job(jobs[i]);

    // Abort during LOAD at address 3; loaded must be cleared so reuse still reloads.
    found = 0;
    @(negedge clk);
    start = 1'b1; reuse = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_rd_en && mem_addr == 3'd3) begin
        rst   = 1'b1;
        found = 1;
      end
    end
    chk("abort_reached_addr3", 128'(found), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_rd_en", 128'(mem_rd_en), 128'(0));
    chk("abort_valid", 128'(out_valid), 128'(0));
    run_job('{1, -1, 0, 0, 8, 10});

    // Default parameters: 750 reads, 100 tiles, last tile of each row zero-padded.
    ntb = 0; bk = 0; bt = 0; bdone = 0;
    @(negedge clk);
    b_start = 1'b1;
    for (int c = 1; c < 1200 && !bdone; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_out_valid) begin
        if (ntb == 0) chk("b_first_valid_cycle", 128'(c), 128'(752));
        expv = '0;
        for (int j = 0; j < 8; j++) begin
          col = bt * 8 + j;
          if (col < 75) expv[j*16 +: 16] = 16'(32'h3F80 + bk * 75 + col);
        end
        chk("b_tile_data", b_out_data, expv);
        chk("b_tile_k", 128'(b_out_k), 128'(bk));
        chk("b_tile_t", 128'(b_out_tile), 128'(bt));
        chk("b_tile_last", 128'(b_out_last), 128'(bk == 9 && bt == 9));
        ntb++;
        if (bt == 9) begin
          bt = 0;
          bk++;
        end else begin
          bt++;
        end
      end
      if (b_done) begin
        chk("b_done_cycle", 128'(c), 128'(852));
        bdone = 1;
      end
    end
    chk("b_tile_count", 128'(ntb), 128'(100));
    chk("b_done_seen", 128'(bdone), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
